// File: rtl/stage_pipe_reg.sv
// stage_pipe_reg: parametrised inter-stage pipeline register carrying the
// writeback, HI/LO and memory payload plus multi-cycle carry state.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   stall[STALL_W]                 global stall vector; this stage reads
//                                  S = stall[STAGE_IDX], D = stall[STAGE_IDX+1]
//   flush                          exception flush, kills stage contents
//   in_*                           upstream payload and valid bit
//   carry_i, cnt_i                 multi-cycle partial result / step from upstream
//   out_*                          registered payload and valid bit
//   carry_o, cnt_o                 carry / step fed back to upstream
//   stall_age                      saturating count of consecutive non-advance cycles
//   perf_bubble/hold/adv           cycle counters, live only with STAGE_PERF_CNT_EN;
//                                  tied to zero (no flops) when the macro is undefined
//
// Cycle classification, highest priority first:
//   flush   : payload -> bubble, carry/cnt/age cleared
//   bubble  : S & !D, payload -> bubble, carry/cnt captured, age++
//   advance : !S, payload <= inputs, carry/cnt/age cleared
//   hold    : S & D, payload kept, carry/cnt captured, age++

module stage_pipe_reg #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned OPW       = 8,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 3,
    parameter int unsigned CARRY_W   = 64,
    parameter int unsigned CNT_W     = 2,
    parameter logic [OPW-1:0] NOP_OP = '0,
    parameter int unsigned AGE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,

    input  logic               in_valid,
    input  logic [AW-1:0]      in_wd,
    input  logic               in_wreg,
    input  logic [DW-1:0]      in_wdata,
    input  logic [DW-1:0]      in_hi,
    input  logic [DW-1:0]      in_lo,
    input  logic               in_whilo,
    input  logic [OPW-1:0]     in_aluop,
    input  logic [DW-1:0]      in_mem_addr,
    input  logic [DW-1:0]      in_reg2,
    input  logic [CARRY_W-1:0] carry_i,
    input  logic [CNT_W-1:0]   cnt_i,

    output logic               out_valid,
    output logic [AW-1:0]      out_wd,
    output logic               out_wreg,
    output logic [DW-1:0]      out_wdata,
    output logic [DW-1:0]      out_hi,
    output logic [DW-1:0]      out_lo,
    output logic               out_whilo,
    output logic [OPW-1:0]     out_aluop,
    output logic [DW-1:0]      out_mem_addr,
    output logic [DW-1:0]      out_reg2,
    output logic [CARRY_W-1:0] carry_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [AGE_W-1:0]   stall_age,

    output logic [31:0]        perf_bubble,
    output logic [31:0]        perf_hold,
    output logic [31:0]        perf_adv
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    typedef struct packed {
        logic [AW-1:0]  wd;
        logic           wreg;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  hi;
        logic [DW-1:0]  lo;
        logic           whilo;
        logic [OPW-1:0] aluop;
        logic [DW-1:0]  mem_addr;
        logic [DW-1:0]  reg2;
    } payload_t;

    // Bubble payload shared by reset, flush and bubble cycles.
    localparam payload_t PL_NOP = '{
        wd:       '0,
        wreg:     1'b0,
        wdata:    '0,
        hi:       '0,
        lo:       '0,
        whilo:    1'b0,
        aluop:    NOP_OP,
        mem_addr: '0,
        reg2:     '0
    };

    // ------------------------------------------------------------------
    // Cycle classification
    // ------------------------------------------------------------------
    logic s_stall;
    logic d_stall;
    logic do_flush;
    logic do_bubble;
    logic do_adv;
    logic do_hold;

    assign s_stall   = stall[STAGE_IDX];
    assign d_stall   = stall[STAGE_IDX+1];

    // The four flags are one-hot by construction.
    assign do_flush  = flush;
    assign do_bubble = !flush &&  s_stall && !d_stall;
    assign do_adv    = !flush && !s_stall;
    assign do_hold   = !flush &&  s_stall &&  d_stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    payload_t               pl_q;
    payload_t               pl_d;
    payload_t               pl_in;
    logic                   valid_q;
    logic                   valid_d;
    logic [CARRY_W-1:0]     carry_q;
    logic [CARRY_W-1:0]     carry_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [AGE_W-1:0]       age_q;
    logic [AGE_W-1:0]       age_d;
    logic [AGE_W-1:0]       age_inc;

    // An invalid slot must never raise a write enable downstream.
    always_comb begin
        pl_in          = '0;
        pl_in.wd       = in_wd;
        pl_in.wreg     = in_wreg & in_valid;
        pl_in.wdata    = in_wdata;
        pl_in.hi       = in_hi;
        pl_in.lo       = in_lo;
        pl_in.whilo    = in_whilo & in_valid;
        pl_in.aluop    = in_aluop;
        pl_in.mem_addr = in_mem_addr;
        pl_in.reg2     = in_reg2;
    end

    assign age_inc = (age_q == AGE_MAX) ? age_q : age_q + AGE_ONE;

    always_comb begin
        pl_d    = pl_q;
        valid_d = valid_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        unique case (1'b1)
            do_flush: begin
                pl_d    = PL_NOP;
                valid_d = 1'b0;
                carry_d = '0;
                cnt_d   = '0;
                age_d   = '0;
            end
            do_bubble: begin
                pl_d    = PL_NOP;
                valid_d = 1'b0;
                carry_d = carry_i;
                cnt_d   = cnt_i;
                age_d   = age_inc;
            end
            do_adv: begin
                pl_d    = pl_in;
                valid_d = in_valid;
                carry_d = '0;
                cnt_d   = '0;
                age_d   = '0;
            end
            do_hold: begin
                carry_d = carry_i;
                cnt_d   = cnt_i;
                age_d   = age_inc;
            end
            default: begin
                pl_d    = pl_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl_q    <= PL_NOP;
            valid_q <= 1'b0;
            carry_q <= '0;
            cnt_q   <= '0;
            age_q   <= '0;
        end else begin
            pl_q    <= pl_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_wd       = pl_q.wd;
    assign out_wreg     = pl_q.wreg;
    assign out_wdata    = pl_q.wdata;
    assign out_hi       = pl_q.hi;
    assign out_lo       = pl_q.lo;
    assign out_whilo    = pl_q.whilo;
    assign out_aluop    = pl_q.aluop;
    assign out_mem_addr = pl_q.mem_addr;
    assign out_reg2     = pl_q.reg2;
    assign carry_o      = carry_q;
    assign cnt_o        = cnt_q;
    assign stall_age    = age_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef STAGE_PERF_CNT_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_bubble_d;
    logic [31:0] perf_hold_q;
    logic [31:0] perf_hold_d;
    logic [31:0] perf_adv_q;
    logic [31:0] perf_adv_d;

    // Flush cycles are deliberately counted in none of the buckets.
    always_comb begin
        perf_bubble_d = perf_bubble_q;
        perf_hold_d   = perf_hold_q;
        perf_adv_d    = perf_adv_q;
        if (do_bubble) perf_bubble_d = perf_bubble_q + 32'd1;
        if (do_hold)   perf_hold_d   = perf_hold_q + 32'd1;
        if (do_adv)    perf_adv_d    = perf_adv_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubble_q <= '0;
            perf_hold_q   <= '0;
            perf_adv_q    <= '0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_hold_q   <= perf_hold_d;
            perf_adv_q    <= perf_adv_d;
        end
    end

    assign perf_bubble = perf_bubble_q;
    assign perf_hold   = perf_hold_q;
    assign perf_adv    = perf_adv_q;
`else
    assign perf_bubble = '0;
    assign perf_hold   = '0;
    assign perf_adv    = '0;
`endif

endmodule
